// File: rtl/incr_stream.sv
// incr_stream: registered valid/ready stage adding 1 or 2 (s_sel) to each beat, two-entry skid buffer.
// Optional beat/wrap statistics are enabled by defining INCR_STREAM_STATS_EN.
//
// state | meaning
// EMPTY | OUT invalid, SKID empty
// ONE   | OUT valid, SKID empty
// TWO   | OUT and SKID both valid, input stalled
module incr_stream #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_sel,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_wrap,
    output logic [CNT_W-1:0]  stat_beats,
    output logic [15:0]       stat_wraps
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t          state, state_nx;
    logic            ready_q;
    logic [DATA_W:0] sum;
    logic [DATA_W:0] out_q;
    logic [DATA_W:0] skid_q;
    logic            acc;
    logic            drn;
    logic            load_out_new;
    logic            load_out_skid;
    logic            load_skid;

    // MSB of the widened sum is the carry that becomes m_wrap
    assign sum = {1'b0, s_data} + (s_sel ? (DATA_W+1)'(2) : (DATA_W+1)'(1));

    assign acc     = s_valid && ready_q;
    assign drn     = m_valid && m_ready;
    assign s_ready = ready_q;
    assign m_valid = (state != EMPTY);
    assign m_data  = out_q[DATA_W-1:0];
    assign m_wrap  = out_q[DATA_W];

    always_comb begin
        state_nx      = state;
        load_out_new  = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        case (state)
            EMPTY: begin
                if (acc) begin
                    state_nx     = ONE;
                    load_out_new = 1'b1;
                end
            end
            ONE: begin
                case ({acc, drn})
                    2'b10: begin
                        state_nx  = TWO;
                        load_skid = 1'b1;
                    end
                    2'b01: state_nx = EMPTY;
                    2'b11: load_out_new = 1'b1;
                    default: state_nx = ONE;
                endcase
            end
            TWO: begin
                if (drn) begin
                    state_nx      = ONE;
                    load_out_skid = 1'b1;
                end
            end
            default: state_nx = EMPTY;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state   <= EMPTY;
            ready_q <= 1'b0;
        end else begin
            state   <= state_nx;
            ready_q <= (state_nx != TWO);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            if (load_out_new)
                out_q <= sum;
            else if (load_out_skid)
                out_q <= skid_q;
            if (load_skid)
                skid_q <= sum;
        end
    end

`ifdef INCR_STREAM_STATS_EN
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            stat_beats <= '0;
            stat_wraps <= '0;
        end else if (drn) begin
            stat_beats <= stat_beats + CNT_W'(1);
            if (m_wrap && (stat_wraps != 16'hFFFF))
                stat_wraps <= stat_wraps + 16'd1;
        end
    end
`else
    assign stat_beats = '0;
    assign stat_wraps = '0;
`endif

endmodule
